// File: rtl/cpu_pkg.sv
// Shared CPU definitions: field widths and the control bundle layout used by
// the ctrl mux, the ID/EX register and the EX/MEM register.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int ALUOP_W      = 5;
    localparam int REG_IDX_W    = 5;

    // Control bundle; field order is shared with the neighbouring stages.
    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_write;
        logic               mem_read;
        logic               branch;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // A bubble carries no side effects: all controls and the ALU op are zero.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // True when the next edge loads a bubble: a flush, or an unstalled load
    // of an empty ID slot.
    function automatic logic loads_bubble(input logic flush,
                                          input logic stall,
                                          input logic valid_in);
        return flush | (~stall & ~valid_in);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset. Sticks at
// all-ones instead of wrapping so long runs stay meaningful.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: add one on inc unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register; reset wins over increment.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Captures the control bundle and decoded operands
// from ID, supports hold (stall) and bubble insertion (flush), tracks a valid
// bit per entry and counts bubbles entering EX.
// Edge priority: reset > flush > stall > load.
module id_ex_reg
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic                 ID_RegWrite,
    input  logic                 ID_MemtoReg,
    input  logic                 ID_MemWrite,
    input  logic                 ID_MemRead,
    input  logic                 ID_Branch,
    input  logic                 ID_ALUSrc,
    input  logic [ALUOP_W-1:0]   ID_ALUOp,
    input  logic [XLEN-1:0]      ID_pc,
    input  logic [XLEN-1:0]      ID_rs1_data,
    input  logic [XLEN-1:0]      ID_rs2_data,
    input  logic [XLEN-1:0]      ID_imm,
    input  logic [REG_IDX_W-1:0] ID_rs1,
    input  logic [REG_IDX_W-1:0] ID_rs2,
    input  logic [REG_IDX_W-1:0] ID_rd,
    output logic                 EX_RegWrite,
    output logic                 EX_MemtoReg,
    output logic                 EX_MemWrite,
    output logic                 EX_MemRead,
    output logic                 EX_Branch,
    output logic                 EX_ALUSrc,
    output logic [ALUOP_W-1:0]   EX_ALUOp,
    output logic [XLEN-1:0]      EX_pc,
    output logic [XLEN-1:0]      EX_rs1_data,
    output logic [XLEN-1:0]      EX_rs2_data,
    output logic [XLEN-1:0]      EX_imm,
    output logic [REG_IDX_W-1:0] EX_rs1,
    output logic [REG_IDX_W-1:0] EX_rs2,
    output logic [REG_IDX_W-1:0] EX_rd,
    output logic                 EX_valid,
    output logic [CNT_W-1:0]     bubble_cnt
);

    ctrl_t                ctrl_in;
    ctrl_t                ctrl_q,     ctrl_d;
    logic [XLEN-1:0]      pc_q,       pc_d;
    logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]      imm_q,      imm_d;
    logic [REG_IDX_W-1:0] rs1_q,      rs1_d;
    logic [REG_IDX_W-1:0] rs2_q,      rs2_d;
    logic [REG_IDX_W-1:0] rd_q,       rd_d;
    logic                 valid_q,    valid_d;
    logic                 bubble_inc;

    // Gather the incoming control bits into the shared bundle layout.
    always_comb begin
        ctrl_in            = CTRL_BUBBLE;
        ctrl_in.reg_write  = ID_RegWrite;
        ctrl_in.mem_to_reg = ID_MemtoReg;
        ctrl_in.mem_write  = ID_MemWrite;
        ctrl_in.mem_read   = ID_MemRead;
        ctrl_in.branch     = ID_Branch;
        ctrl_in.alu_src    = ID_ALUSrc;
        ctrl_in.alu_op     = ID_ALUOp;
    end

    // Next-state selection: flush bubbles, stall holds, otherwise load.
    always_comb begin
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        valid_d    = valid_q;
        if (flush) begin
            // Data fields keep their old values; only the side-effecting
            // parts and the indices (to avoid false forwarding hits) clear.
            ctrl_d  = CTRL_BUBBLE;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d       = ID_pc;
            rs1_data_d = ID_rs1_data;
            rs2_data_d = ID_rs2_data;
            imm_d      = ID_imm;
            valid_d    = valid_in;
            if (valid_in) begin
                ctrl_d = ctrl_in;
                rs1_d  = ID_rs1;
                rs2_d  = ID_rs2;
                rd_d   = ID_rd;
            end else begin
                ctrl_d = CTRL_BUBBLE;
                rs1_d  = '0;
                rs2_d  = '0;
                rd_d   = '0;
            end
        end
    end

    // Pipeline register; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctrl_q     <= CTRL_BUBBLE;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
        end
    end

    assign bubble_inc = loads_bubble(flush, stall, valid_in);

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    assign EX_RegWrite = ctrl_q.reg_write;
    assign EX_MemtoReg = ctrl_q.mem_to_reg;
    assign EX_MemWrite = ctrl_q.mem_write;
    assign EX_MemRead  = ctrl_q.mem_read;
    assign EX_Branch   = ctrl_q.branch;
    assign EX_ALUSrc   = ctrl_q.alu_src;
    assign EX_ALUOp    = ctrl_q.alu_op;
    assign EX_pc       = pc_q;
    assign EX_rs1_data = rs1_data_q;
    assign EX_rs2_data = rs2_data_q;
    assign EX_imm      = imm_q;
    assign EX_rs1      = rs1_q;
    assign EX_rs2      = rs2_q;
    assign EX_rd       = rd_q;
    assign EX_valid    = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed steps plus a short random run, with a
// reference model feeding an expected queue; a second instance with a
// 4-bit counter covers saturation.
module tb_id_ex_reg;

    localparam int XLEN = 32;
    localparam int DW   = 6 + 5 + 4 * XLEN + 15 + 1;
    localparam int EW   = DW + 32 + 4;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn = 1'b0;
    logic            stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
    logic            ID_RegWrite = 0, ID_MemtoReg = 0, ID_MemWrite = 0;
    logic            ID_MemRead = 0, ID_Branch = 0, ID_ALUSrc = 0;
    logic [4:0]      ID_ALUOp = '0, ID_rs1 = '0, ID_rs2 = '0, ID_rd = '0;
    logic [XLEN-1:0] ID_pc = '0, ID_rs1_data = '0, ID_rs2_data = '0, ID_imm = '0;

    logic            EX_RegWrite, EX_MemtoReg, EX_MemWrite, EX_MemRead, EX_Branch, EX_ALUSrc;
    logic [4:0]      EX_ALUOp, EX_rs1, EX_rs2, EX_rd;
    logic [XLEN-1:0] EX_pc, EX_rs1_data, EX_rs2_data, EX_imm;
    logic            EX_valid;
    logic [31:0]     bubble_cnt;

    logic            d4_RegWrite, d4_MemtoReg, d4_MemWrite, d4_MemRead, d4_Branch, d4_ALUSrc;
    logic [4:0]      d4_ALUOp, d4_rs1, d4_rs2, d4_rd;
    logic [XLEN-1:0] d4_pc, d4_rs1_data, d4_rs2_data, d4_imm;
    logic            d4_valid;
    logic [3:0]      d4_cnt;

    id_ex_reg #(.XLEN(XLEN), .CNT_W(32)) u_dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .valid_in(valid_in),
        .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg), .ID_MemWrite(ID_MemWrite),
        .ID_MemRead(ID_MemRead), .ID_Branch(ID_Branch), .ID_ALUSrc(ID_ALUSrc),
        .ID_ALUOp(ID_ALUOp), .ID_pc(ID_pc), .ID_rs1_data(ID_rs1_data),
        .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rd(ID_rd),
        .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg), .EX_MemWrite(EX_MemWrite),
        .EX_MemRead(EX_MemRead), .EX_Branch(EX_Branch), .EX_ALUSrc(EX_ALUSrc),
        .EX_ALUOp(EX_ALUOp), .EX_pc(EX_pc), .EX_rs1_data(EX_rs1_data),
        .EX_rs2_data(EX_rs2_data), .EX_imm(EX_imm), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2),
        .EX_rd(EX_rd), .EX_valid(EX_valid), .bubble_cnt(bubble_cnt)
    );

    id_ex_reg #(.XLEN(XLEN), .CNT_W(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush), .valid_in(valid_in),
        .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg), .ID_MemWrite(ID_MemWrite),
        .ID_MemRead(ID_MemRead), .ID_Branch(ID_Branch), .ID_ALUSrc(ID_ALUSrc),
        .ID_ALUOp(ID_ALUOp), .ID_pc(ID_pc), .ID_rs1_data(ID_rs1_data),
        .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rd(ID_rd),
        .EX_RegWrite(d4_RegWrite), .EX_MemtoReg(d4_MemtoReg), .EX_MemWrite(d4_MemWrite),
        .EX_MemRead(d4_MemRead), .EX_Branch(d4_Branch), .EX_ALUSrc(d4_ALUSrc),
        .EX_ALUOp(d4_ALUOp), .EX_pc(d4_pc), .EX_rs1_data(d4_rs1_data),
        .EX_rs2_data(d4_rs2_data), .EX_imm(d4_imm), .EX_rs1(d4_rs1), .EX_rs2(d4_rs2),
        .EX_rd(d4_rd), .EX_valid(d4_valid), .bubble_cnt(d4_cnt)
    );

    logic [DW-1:0] obs_data, obs4_data;
    assign obs_data  = {EX_RegWrite, EX_MemtoReg, EX_MemWrite, EX_MemRead, EX_Branch, EX_ALUSrc,
                        EX_ALUOp, EX_pc, EX_rs1_data, EX_rs2_data, EX_imm,
                        EX_rs1, EX_rs2, EX_rd, EX_valid};
    assign obs4_data = {d4_RegWrite, d4_MemtoReg, d4_MemWrite, d4_MemRead, d4_Branch, d4_ALUSrc,
                        d4_ALUOp, d4_pc, d4_rs1_data, d4_rs2_data, d4_imm,
                        d4_rs1, d4_rs2, d4_rd, d4_valid};

    // Reference model state
    logic [5:0]      m_ctrl;
    logic [4:0]      m_alu, m_rs1, m_rs2, m_rd;
    logic [XLEN-1:0] m_pc, m_r1d, m_r2d, m_imm;
    logic            m_valid;
    logic [31:0]     m_cnt32;
    logic [3:0]      m_cnt4;

    // Scoreboard
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        if (!rstn) begin
            m_ctrl = '0; m_alu = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_pc = '0; m_r1d = '0; m_r2d = '0; m_imm = '0; m_valid = 1'b0;
            m_cnt32 = '0; m_cnt4 = '0;
        end else begin
            logic bub;
            bub = 1'b0;
            if (flush) begin
                m_ctrl = '0; m_alu = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
                m_valid = 1'b0;
                bub = 1'b1;
            end else if (!stall) begin
                m_pc = ID_pc; m_r1d = ID_rs1_data; m_r2d = ID_rs2_data; m_imm = ID_imm;
                m_valid = valid_in;
                if (valid_in) begin
                    m_ctrl = {ID_RegWrite, ID_MemtoReg, ID_MemWrite, ID_MemRead, ID_Branch, ID_ALUSrc};
                    m_alu = ID_ALUOp; m_rs1 = ID_rs1; m_rs2 = ID_rs2; m_rd = ID_rd;
                end else begin
                    m_ctrl = '0; m_alu = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
                    bub = 1'b1;
                end
            end
            if (bub && m_cnt32 != 32'hFFFF_FFFF) m_cnt32 = m_cnt32 + 32'd1;
            if (bub && m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
        end
    endtask

    // Driver: randomize every ID field
    task automatic rand_id();
        {ID_RegWrite, ID_MemtoReg, ID_MemWrite, ID_MemRead, ID_Branch, ID_ALUSrc} = 6'($urandom_range(1, 63));
        ID_ALUOp = 5'($urandom_range(1, 31));
        ID_rs1 = 5'($urandom_range(1, 31));
        ID_rs2 = 5'($urandom_range(1, 31));
        ID_rd  = 5'($urandom_range(1, 31));
        ID_pc  = $urandom | 32'h1;
        ID_rs1_data = $urandom | 32'h1;
        ID_rs2_data = $urandom | 32'h1;
        ID_imm = $urandom | 32'h1;
    endtask

    // One clock: predict, push, clock, pop and compare
    task automatic step(input string tag);
        logic [EW-1:0] e;
        model_update();
        exp_q.push_back({m_ctrl, m_alu, m_pc, m_r1d, m_r2d, m_imm, m_rs1, m_rs2, m_rd,
                         m_valid, m_cnt32, m_cnt4});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {obs_data, bubble_cnt, d4_cnt}, e);
        check({tag, "_c4"}, obs4_data, e[EW-1 -: DW]);
        check({tag, "_inv"},
              {EX_RegWrite, EX_MemWrite, EX_MemRead, EX_Branch, EX_rd} & {9{~EX_valid}}, 0);
    endtask

    initial begin
        logic [31:0] cnt_before;

        // Reset with busy inputs
        rand_id();
        valid_in = 1'b1; stall = 1'b1; flush = 1'b1; rstn = 1'b0;
        step("reset");
        check("reset_valid", EX_valid, 0);
        check("reset_cnt", bubble_cnt, 0);
        check("reset_pc", EX_pc, 0);

        // Plain load
        rstn = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b1;
        rand_id();
        ID_pc = 32'h100; ID_rd = 5'd5; ID_RegWrite = 1'b1; ID_ALUOp = 5'd3;
        step("load");
        check("load_pc", EX_pc, 32'h100);
        check("load_rd", EX_rd, 5);
        check("load_regwrite", EX_RegWrite, 1);
        check("load_aluop", EX_ALUOp, 3);
        check("load_valid", EX_valid, 1);
        cnt_before = bubble_cnt;

        // Stall three cycles while ID moves on
        stall = 1'b1;
        ID_pc = 32'h104;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check("stall_pc", EX_pc, 32'h100);
            check("stall_cnt", bubble_cnt, cnt_before);
        end
        stall = 1'b0;
        step("stall_release");
        check("release_pc", EX_pc, 32'h104);

        // Reload pc 0x100 / rd 5, then flush and stall together
        ID_pc = 32'h100; ID_rd = 5'd5;
        step("reload");
        cnt_before = bubble_cnt;
        flush = 1'b1; stall = 1'b1;
        rand_id();
        step("flush_stall");
        check("fs_valid", EX_valid, 0);
        check("fs_rd", EX_rd, 0);
        check("fs_pc", EX_pc, 32'h100);
        check("fs_cnt", bubble_cnt, cnt_before + 32'd1);

        // Empty ID slot with live-looking controls
        flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
        ID_MemWrite = 1'b1; ID_rd = 5'd7;
        step("invalid_load");
        check("inv_memwrite", EX_MemWrite, 0);
        check("inv_rd", EX_rd, 0);
        check("inv_valid", EX_valid, 0);
        check("inv_cnt", bubble_cnt, cnt_before + 32'd2);

        // Random mix
        for (int i = 0; i < 12; i++) begin
            rand_id();
            valid_in = 1'($urandom_range(0, 1));
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 4) == 0);
            step("random");
        end

        // Reset deasserted mid-stall: first edge after reset holds
        stall = 1'b1; flush = 1'b0; rstn = 1'b0;
        step("mid_reset");
        rstn = 1'b1; rand_id(); valid_in = 1'b1;
        step("post_reset_stall");
        check("prs_valid", EX_valid, 0);
        stall = 1'b0;
        step("post_reset_load");

        // Saturation of the 4-bit counter
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("sat");
        end
        check("sat_cnt4", d4_cnt, 4'hF);
        step("sat_hold");
        check("sat_cnt4_hold", d4_cnt, 4'hF);
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
